sha256_block_engine: RTL and testbench

//  Parametrised SHA-256 compression engine for the bitcoin hashing datapath.

---
 rtl/sha256_pkg.sv | 72 +++++++
 rtl/sha256_round.sv | 31 +++
 rtl/sha256_block_engine.sv | 158 +++++++++++++++
 tb/tb_sha256_block_engine.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, types and bit functions.
//   mode_e  : message source selector for the block engine
//   hash_t  : eight 32-bit words, index 0 = word a / H0
//   K, IV   : round constants and initial hash value
//   ror, sigma0/1, big_sigma0/1, ch, maj : FIPS 180-4 helper functions
package sha256_pkg;

   typedef enum logic [1:0] {
      ModeBlock  = 2'd0,
      ModeTail   = 2'd1,
      ModeRehash = 2'd2,
      ModeRsvd   = 2'd3
   } mode_e;

   typedef logic [7:0][31:0] hash_t;

   localparam logic [31:0] PadWord = 32'h8000_0000;

   // Packed: rightmost literal is word 0.
   localparam hash_t IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                           32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   state_in  : working variables a..h (index 0 = a)
//   w, k      : schedule word and round constant for this round
//   state_out : working variables after the round
module sha256_round
   import sha256_pkg::*;
(
   input  hash_t       state_in,
   input  logic [31:0] w,
   input  logic [31:0] k,
   output hash_t       state_out
);

   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1 = state_in[7] + big_sigma1(state_in[4]) + ch(state_in[4], state_in[5], state_in[6])
           + k + w;
      t2 = big_sigma0(state_in[0]) + maj(state_in[0], state_in[1], state_in[2]);
      state_out[0] = t1 + t2;
      state_out[1] = state_in[0];
      state_out[2] = state_in[1];
      state_out[3] = state_in[2];
      state_out[4] = state_in[3] + t1;
      state_out[5] = state_in[4];
      state_out[6] = state_in[5];
      state_out[7] = state_in[6];
   end

endmodule

// File: rtl/sha256_block_engine.sv
// sha256_block_engine: SHA-256 compression of one 512-bit block per start.
//   clk, reset      : clock, synchronous active-high reset
//   start           : request, accepted only in the idle state
//   mode            : 0 block, 1 tail+nonce, 2 rehash of hi, 3 treated as block
//   chain           : 1 -> initial hash is current ho, 0 -> initial hash is hi
//   hi, blk         : initial hash (also rehash message), raw message words
//   msg_tail, nonce : header words 16..18 and nonce for tail mode
//   busy, done, ho  : busy through the done cycle, done pulse, held digest
module sha256_block_engine
   import sha256_pkg::*;
#(
   parameter int unsigned ROUNDS_PER_CYCLE = 1,
   parameter int unsigned NONCE_WIDTH      = 32,
   parameter int unsigned TAIL_LEN_BITS    = 640
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [1:0]             mode,
   input  logic                   chain,
   input  logic [7:0][31:0]       hi,
   input  logic [15:0][31:0]      blk,
   input  logic [2:0][31:0]       msg_tail,
   input  logic [NONCE_WIDTH-1:0] nonce,
   output logic                   busy,
   output logic                   done,
   output logic [7:0][31:0]       ho
);

   localparam int unsigned R     = ROUNDS_PER_CYCLE;
   localparam logic [5:0]  LastT = 6'(64 - R);

   typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

   state_e            state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   hash_t             hinit_q, hinit_d;
   hash_t             work_q, work_d;
   hash_t             ho_q, ho_d;
   logic [15:0][31:0] win_q, win_d;
   logic              done_q, done_d;

   mode_e             mode_sel;
   logic [15:0][31:0] msg;
   logic [15:0][31:0] win_next;
   hash_t             rnd_out;

   assign mode_sel = mode_e'(mode);

   always_comb begin
      msg = '0;
      case (mode_sel)
         ModeTail: begin
            msg[2:0] = msg_tail;
            msg[3]   = 32'(nonce);
            msg[4]   = PadWord;
            msg[15]  = 32'(TAIL_LEN_BITS);
         end
         ModeRehash: begin
            msg[7:0] = hi;
            msg[8]   = PadWord;
            msg[15]  = 32'd256;
         end
         default: msg = blk;
      endcase
   end

   // Window holds w[t..t+15]; extend by R words (later ones may depend on earlier new ones),
   // then drop the R oldest.
   always_comb begin : p_sched
      logic [31:0] ext [16 + R];
      for (int i = 0; i < 16; i++) ext[i] = win_q[i];
      for (int j = 0; j < int'(R); j++) begin
         ext[16 + j] = ext[j] + sigma0(ext[j + 1]) + ext[j + 9] + sigma1(ext[j + 14]);
      end
      for (int i = 0; i < 16; i++) win_next[i] = ext[i + int'(R)];
   end

   // Round j of a cycle consumes window word j and K[t+j].
   for (genvar j = 0; j < int'(R); j++) begin : g_round
      hash_t       st_in;
      hash_t       st_out;
      logic [31:0] k_word;
      if (j == 0) begin : g_first
         assign st_in = work_q;
      end else begin : g_next
         assign st_in = g_round[j - 1].st_out;
      end
      assign k_word = K[cnt_q + 6'(j)];
      sha256_round u_round (
         .state_in  (st_in),
         .w         (win_q[j]),
         .k         (k_word),
         .state_out (st_out)
      );
   end

   assign rnd_out = g_round[R - 1].st_out;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hinit_d = hinit_q;
      work_d  = work_q;
      win_d   = win_q;
      ho_d    = ho_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               hinit_d = chain ? ho_q : hi;
               work_d  = hinit_d;
               win_d   = msg;
               cnt_d   = '0;
               state_d = StRound;
            end
         end
         StRound: begin
            work_d = rnd_out;
            win_d  = win_next;
            cnt_d  = cnt_q + 6'(R);
            if (cnt_q == LastT) state_d = StFinal;
         end
         StFinal: begin
            for (int i = 0; i < 8; i++) ho_d[i] = hinit_q[i] + work_q[i];
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hinit_q <= '0;
         work_q  <= '0;
         win_q   <= '0;
         ho_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hinit_q <= hinit_d;
         work_q  <= work_d;
         win_q   <= win_d;
         ho_q    <= ho_d;
         done_q  <= done_d;
      end
   end

   // The done cycle is already idle, so busy is extended by the done pulse.
   assign busy = (state_q != StIdle) | done_q;
   assign done = done_q;
   assign ho   = ho_q;

endmodule

// File: tb/tb_sha256_block_engine.sv
// tb_sha256_block_engine: three engines (R = 1, 2, 4) share stimulus; a reference
// SHA-256 model predicts done timing, busy and ho for every cycle.
module tb_sha256_block_engine;

   typedef logic [7:0][31:0]  h8_t;
   typedef logic [15:0][31:0] w16_t;
   typedef struct {int e0; int dn; h8_t h;} job_t;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] AbcDigest =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] NistDigest =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   logic               clk = 1'b0;
   logic               reset;
   logic [2:0]         start;
   logic [1:0]         mode;
   logic               chain;
   h8_t                hi;
   w16_t               blk;
   logic [2:0][31:0]   msg_tail;
   logic [31:0]        nonce;
   logic [2:0]         busy_v;
   logic [2:0]         done_v;
   h8_t                ho_v [3];

   int   cyc = 0;
   bit   chk_en = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   done_cnt [3] = '{0, 0, 0};
   job_t jobs [3][$];
   h8_t  cur_ho [3] = '{'0, '0, '0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sha256_block_engine #(
         .ROUNDS_PER_CYCLE (1 << g),
         .NONCE_WIDTH      (32),
         .TAIL_LEN_BITS    (640)
      ) u_dut (
         .clk      (clk),
         .reset    (reset),
         .start    (start[g]),
         .mode     (mode),
         .chain    (chain),
         .hi       (hi),
         .blk      (blk),
         .msg_tail (msg_tail),
         .nonce    (nonce),
         .busy     (busy_v[g]),
         .done     (done_v[g]),
         .ho       (ho_v[g])
      );
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotr(logic [31:0] x, int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic h8_t compress(h8_t hin, w16_t m);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2, s0, s1;
      h8_t         r;
      for (int t = 0; t < 64; t++) begin
         if (t < 16) w[t] = m[t];
         else begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
         end
      end
      for (int i = 0; i < 8; i++) v[i] = hin[i];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
              + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[i] = hin[i] + v[i];
      return r;
   endfunction

   function automatic w16_t build(logic [1:0] md, h8_t h, w16_t b, logic [2:0][31:0] tl,
                                  logic [31:0] nc);
      w16_t m = '0;
      if (md == 2'd1) begin
         m[0] = tl[0]; m[1] = tl[1]; m[2] = tl[2]; m[3] = nc;
         m[4] = 32'h80000000; m[15] = 32'd640;
      end else if (md == 2'd2) begin
         for (int i = 0; i < 8; i++) m[i] = h[i];
         m[8] = 32'h80000000; m[15] = 32'd256;
      end else m = b;
      return m;
   endfunction

   function automatic h8_t mk8(logic [255:0] v);
      h8_t r;
      for (int i = 0; i < 8; i++) r[i] = v[255 - 32*i -: 32];
      return r;
   endfunction

   function automatic w16_t mk16(logic [511:0] v);
      w16_t r;
      for (int i = 0; i < 16; i++) r[i] = v[511 - 32*i -: 32];
      return r;
   endfunction

   function automatic int lat(int d);
      return 64 / (1 << d) + 1;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            logic exp_done, exp_busy;
            exp_done = (jobs[d].size() > 0) && (jobs[d][0].dn == cyc);
            exp_busy = (jobs[d].size() > 0) && (jobs[d][0].e0 <= cyc);
            if (exp_done) cur_ho[d] = jobs[d][0].h;
            chk($sformatf("done[%0d]", d), 256'(done_v[d]), 256'(exp_done));
            chk($sformatf("busy[%0d]", d), 256'(busy_v[d]), 256'(exp_busy));
            chk($sformatf("ho[%0d]", d), ho_v[d], cur_ho[d]);
            if (done_v[d] === 1'b1) done_cnt[d]++;
            if (exp_done) void'(jobs[d].pop_front());
         end
      end
   end

   // ---------------- stimulus helpers (called just after a rising edge) ----------------
   task automatic issue(input logic [2:0] which);
      for (int d = 0; d < 3; d++) begin
         if (which[d] && (jobs[d].size() == 0 || jobs[d][jobs[d].size() - 1].dn <= cyc)) begin
            h8_t  hin;
            job_t jb;
            if (!chain) hin = hi;
            else if (jobs[d].size() > 0) hin = jobs[d][jobs[d].size() - 1].h;
            else hin = cur_ho[d];
            jb.e0 = cyc + 1;
            jb.dn = cyc + 1 + lat(d);
            jb.h  = compress(hin, build(mode, hi, blk, msg_tail, nonce));
            jobs[d].push_back(jb);
         end
      end
      start = which;
      @(posedge clk); #1;
      start = '0;
   endtask

   task automatic wait_done(input int d, input int max, output int n);
      n = 0;
      for (int i = 1; i <= max; i++) begin
         @(posedge clk); #1;
         if (done_v[d] === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_idle(input int max);
      bit ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(posedge clk); #1;
         if (jobs[0].size() == 0 && jobs[1].size() == 0 && jobs[2].size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_wait", 256'(ok), 256'(1));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         jobs[d].delete();
         cur_ho[d] = '0;
      end
      #1 reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int   n;
      int   dc [3];
      w16_t abc_blk;
      abc_blk  = mk16({32'h61626380, 448'h0, 32'h00000018});
      start    = '0;
      mode     = 2'd0;
      chain    = 1'b0;
      hi       = sha256_pkg::IV;
      blk      = '0;
      msg_tail = '0;
      nonce    = '0;
      reset    = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;

      // "abc" on all lanes, R=1 latency and digest pinned by literals
      blk = abc_blk;
      issue(3'b111);
      wait_done(0, 80, n);
      chk("abc_latency_r1", 256'(n), 256'(65));
      chk("abc_digest", ho_v[0], mk8(AbcDigest));
      wait_idle(10);

      // empty message, R=4
      blk = mk16({32'h80000000, 480'h0});
      issue(3'b111);
      wait_done(2, 30, n);
      chk("empty_latency_r4", 256'(n), 256'(17));
      chk("empty_ho0", 256'(ho_v[2][0]), 256'(32'he3b0c442));
      chk("empty_ho7", 256'(ho_v[2][7]), 256'(32'h7852b855));
      wait_idle(80);

      // two-block NIST message, second start in the done cycle with chain=1
      for (int d = 0; d < 3; d++) begin
         chain = 1'b0;
         blk = mk16({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                     32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                     32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000,
                     32'h00000000});
         issue(3'(1 << d));
         wait_done(d, 80, n);
         chk($sformatf("nist_blk1_seen[%0d]", d), 256'(n > 0), 256'(1));
         blk   = mk16({480'h0, 32'h000001c0});
         chain = 1'b1;
         issue(3'(1 << d));
         wait_done(d, 80, n);
         chk($sformatf("nist_digest[%0d]", d), ho_v[d], mk8(NistDigest));
         wait_idle(10);
      end
      chain = 1'b0;

      // start while busy is ignored; reserved mode behaves as block
      for (int d = 0; d < 3; d++) dc[d] = done_cnt[d];
      mode = 2'd3;
      blk  = mk16({16{32'h0badf00d}});
      issue(3'b111);
      repeat (8) @(posedge clk);
      #1;
      mode  = 2'd1;
      nonce = 32'h12345678;
      blk   = abc_blk;
      hi    = mk8({8{32'hdeadbeef}});
      issue(3'b111);
      wait_idle(80);
      for (int d = 0; d < 3; d++)
         chk($sformatf("busy_start_done_count[%0d]", d), 256'(done_cnt[d] - dc[d]), 256'(1));
      hi   = sha256_pkg::IV;
      mode = 2'd0;

      // reset at cycle 30 of a run aborts; nothing follows; a fresh start completes
      for (int d = 0; d < 3; d++) dc[d] = done_cnt[d];
      blk = abc_blk;
      issue(3'b111);
      repeat (29) @(posedge clk);
      #1;
      do_reset();
      repeat (80) @(posedge clk);
      #1;
      chk("reset_abort_no_done_r1", 256'(done_cnt[0] - dc[0]), 256'(0));
      chk("reset_abort_no_done_r2", 256'(done_cnt[1] - dc[1]), 256'(0));
      issue(3'b111);
      wait_idle(80);
      chk("abc_after_reset", ho_v[0], mk8(AbcDigest));

      // tail + nonce and rehash sweeps against the model
      msg_tail[0] = 32'h4d3a2b1c;
      msg_tail[1] = 32'h1d00ffff;
      msg_tail[2] = 32'h5f2e3c4b;
      for (int k = 0; k < 16; k++) begin
         mode  = 2'd1;
         chain = 1'b0;
         hi    = sha256_pkg::IV;
         nonce = k;
         issue(3'b111);
         wait_idle(80);
         mode  = 2'd2;
         chain = k[0];
         for (int i = 0; i < 8; i++) hi[i] = 32'h9e3779b9 * (k * 8 + i + 1);
         issue(3'b111);
         wait_idle(80);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
